// File: rtl/das_shot_scheduler.sv
// Shot-timing controller for the DAS probe path: emits per-shot pulse start strobes,
// the latched probe width and the ADC acquisition window, all in the ADC clock domain.
module das_shot_scheduler #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk_adc_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] pulse_width_i,
  input  logic [CNT_W-1:0] acq_delay_i,
  input  logic [CNT_W-1:0] acq_len_i,
  input  logic [IDX_W-1:0] shot_count_i,
  output logic             pulse_start_o,
  output logic [CNT_W-1:0] pulse_width_o,
  output logic             acq_valid_o,
  output logic             frame_start_o,
  output logic [IDX_W-1:0] shot_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] pos;
  logic             stop_pending;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_len;
  logic [IDX_W-1:0] cfg_count;

  logic [CNT_W:0]   sum_in;
  logic             cfg_ok;
  logic             launch;
  logic             reject;
  logic             shot_end;
  logic             last_shot;
  logic             finish;
  logic             nxt_run;
  logic [CNT_W-1:0] nxt_pos;
  logic [CNT_W-1:0] nxt_delay;
  logic [CNT_W-1:0] nxt_len;
  logic [CNT_W:0]   win_end;

  // The window bound is formed one bit wider so delay+len can never wrap.
  always_comb begin
    sum_in    = {1'b0, acq_delay_i} + {1'b0, acq_len_i};
    cfg_ok    = (period_i >= CNT_W'(2)) && (pulse_width_i != '0) &&
                (pulse_width_i < period_i) && (sum_in <= {1'b0, period_i});
    launch    = (state == IDLE) && start_i && !stop_i && cfg_ok;
    reject    = (state == IDLE) && start_i && !stop_i && !cfg_ok;
    shot_end  = (state == RUN) && (pos == cfg_period - CNT_W'(1));
    last_shot = (cfg_count != '0) && (shot_idx_o == cfg_count - IDX_W'(1));
    finish    = shot_end && (stop_pending || stop_i || last_shot);
    nxt_run   = launch || ((state == RUN) && !finish);
    nxt_pos   = '0;
    if ((state == RUN) && !shot_end) begin
      nxt_pos = pos + CNT_W'(1);
    end
    nxt_delay = launch ? acq_delay_i : cfg_delay;
    nxt_len   = launch ? acq_len_i : cfg_len;
    win_end   = {1'b0, nxt_delay} + {1'b0, nxt_len};
  end

  // Strobes and window are registered from the next position so they line up with pos.
  always_ff @(posedge clk_adc_i) begin
    if (reset_i) begin
      state         <= IDLE;
      pos           <= '0;
      stop_pending  <= 1'b0;
      cfg_period    <= '0;
      cfg_delay     <= '0;
      cfg_len       <= '0;
      cfg_count     <= '0;
      pulse_start_o <= 1'b0;
      pulse_width_o <= '0;
      acq_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      shot_idx_o    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
    end else begin
      state        <= nxt_run ? RUN : IDLE;
      pos          <= nxt_run ? nxt_pos : '0;
      stop_pending <= (state == RUN) && !finish && (stop_pending || stop_i);
      if (launch) begin
        cfg_period    <= period_i;
        cfg_delay     <= acq_delay_i;
        cfg_len       <= acq_len_i;
        cfg_count     <= shot_count_i;
        pulse_width_o <= pulse_width_i;
        shot_idx_o    <= '0;
        cfg_err_o     <= 1'b0;
      end else if (reject) begin
        cfg_err_o <= 1'b1;
      end else if (shot_end && !finish) begin
        shot_idx_o <= shot_idx_o + IDX_W'(1);
      end
      pulse_start_o <= nxt_run && (nxt_pos == '0);
      acq_valid_o   <= nxt_run && ({1'b0, nxt_pos} >= {1'b0, nxt_delay}) &&
                       ({1'b0, nxt_pos} < win_end);
      frame_start_o <= nxt_run && (nxt_pos == nxt_delay) && (nxt_len != '0);
      busy_o        <= nxt_run;
      done_o        <= finish;
    end
  end

endmodule

// File: tb/tb_das_shot_scheduler.sv
// Directed bench for das_shot_scheduler: per-cycle strobe/window vectors are queued
// from hand-derived cycle numbers and popped against the DUT outputs.
module tb_das_shot_scheduler;
  localparam int CNT_W = 32;
  localparam int IDX_W = 2;

  logic             clk_adc_i = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic             stop_i;
  logic [CNT_W-1:0] period_i;
  logic [CNT_W-1:0] pulse_width_i;
  logic [CNT_W-1:0] acq_delay_i;
  logic [CNT_W-1:0] acq_len_i;
  logic [IDX_W-1:0] shot_count_i;
  logic             pulse_start_o;
  logic [CNT_W-1:0] pulse_width_o;
  logic             acq_valid_o;
  logic             frame_start_o;
  logic [IDX_W-1:0] shot_idx_o;
  logic             busy_o;
  logic             done_o;
  logic             cfg_err_o;

  int total = 0;
  int bad   = 0;
  // {pulse_start, acq_valid, frame_start, done, busy, cfg_err}
  logic [5:0] exp_q[$];

  das_shot_scheduler #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk_adc_i(clk_adc_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .period_i(period_i), .pulse_width_i(pulse_width_i), .acq_delay_i(acq_delay_i),
    .acq_len_i(acq_len_i), .shot_count_i(shot_count_i), .pulse_start_o(pulse_start_o),
    .pulse_width_o(pulse_width_o), .acq_valid_o(acq_valid_o), .frame_start_o(frame_start_o),
    .shot_idx_o(shot_idx_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
  );

  // clock / reset
  always #5 clk_adc_i = ~clk_adc_i;

  task automatic step();
    @(posedge clk_adc_i);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {pulse_start_o, acq_valid_o, frame_start_o, done_o, busy_o, cfg_err_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] w,
                         input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] l,
                         input logic [IDX_W-1:0] c);
    period_i = p; pulse_width_i = w; acq_delay_i = d; acq_len_i = l; shot_count_i = c;
  endtask

  task automatic reject_case(input string tag, input logic [CNT_W-1:0] p,
                             input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] d,
                             input logic [CNT_W-1:0] l);
    set_cfg(p, w, d, l, 2'd1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check(tag, 32'(obs()), 32'(6'b000001));
    step();
    check(tag, 32'(obs()), 32'(6'b000001));
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    set_cfg('0, '0, '0, '0, '0);
    step();
    step();
    check("reset_outputs", 32'(obs()), 32'(6'b0));
    check("reset_width", pulse_width_o, 32'd0);
    reset_i = 1'b0;
    step();

    // Finite run, 3 shots of period 10; config changes mid-run must be ignored.
    for (int k = 1; k <= 34; k++) begin
      logic p, a, f;
      p = (k == 1) || (k == 11) || (k == 21);
      a = (k >= 3 && k <= 7) || (k >= 13 && k <= 17) || (k >= 23 && k <= 27);
      f = (k == 3) || (k == 13) || (k == 23);
      exp_q.push_back({p, a, f, k == 31, k <= 30, 1'b0});
    end
    set_cfg(32'd10, 32'd3, 32'd2, 32'd5, 2'd3);
    start_i = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      if (k == 5) begin period_i = 32'd7; pulse_width_i = 32'd9; end
      if (k == 12) start_i = 1'b1;
      if (k == 13) start_i = 1'b0;
      check($sformatf("finite_k%0d", k), 32'(obs()), 32'(exp_q.pop_front()));
      if (k == 1)  check("finite_width", pulse_width_o, 32'd3);
      if (k == 1)  check("finite_idx0", 32'(shot_idx_o), 32'd0);
      if (k == 11) check("finite_idx1", 32'(shot_idx_o), 32'd1);
      if (k == 21) check("finite_idx2", 32'(shot_idx_o), 32'd2);
      if (k == 25) check("finite_width_held", pulse_width_o, 32'd3);
    end

    // Rejections: window overflow, zero width, width == period, wide-sum wrap.
    reject_case("rej_window", 32'd8, 32'd3, 32'd5, 32'd4);
    reject_case("rej_width0", 32'd8, 32'd0, 32'd0, 32'd0);
    reject_case("rej_width_eq_period", 32'd8, 32'd8, 32'd0, 32'd0);
    reject_case("rej_sum_wrap", 32'd8, 32'd3, 32'hFFFF_FFFF, 32'd2);

    // Start and stop together: no run, sticky error unchanged.
    set_cfg(32'd8, 32'd2, 32'd4, 32'd4, 2'd1);
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check("startstop_err_kept", 32'(obs()), 32'(6'b000001));

    // Valid start with delay+len == period clears the error; single shot.
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back({k == 1, k >= 5 && k <= 8, k == 5, k == 9, k <= 8, 1'b0});
    end
    start_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      start_i = 1'b0;
      check($sformatf("single_k%0d", k), 32'(obs()), 32'(exp_q.pop_front()));
    end

    // Start+stop with an invalid config: error stays clear.
    set_cfg(32'd8, 32'd0, 32'd0, 32'd0, 2'd1);
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check("startstop_no_err", 32'(obs()), 32'(6'b000000));

    // Continuous mode, period 4; stop at pos 1 of shot 5. Index wraps 3 -> 0.
    for (int k = 1; k <= 28; k++) begin
      exp_q.push_back({(k % 4 == 1) && k <= 21, (k % 4 == 2 || k % 4 == 3) && k <= 24,
                       (k % 4 == 2) && k <= 24, k == 25, k <= 24, 1'b0});
    end
    set_cfg(32'd4, 32'd1, 32'd1, 32'd2, 2'd0);
    start_i = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      if (k == 22) stop_i = 1'b1;
      if (k == 23) stop_i = 1'b0;
      check($sformatf("cont_k%0d", k), 32'(obs()), 32'(exp_q.pop_front()));
      if (k == 13) check("cont_idx3", 32'(shot_idx_o), 32'd3);
      if (k == 17) check("cont_idx_wrap", 32'(shot_idx_o), 32'd0);
      if (k == 21) check("cont_idx5", 32'(shot_idx_o), 32'd1);
    end

    // Full-period window: acq_valid continuous, frame coincides with pulse.
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back({k == 1 || k == 7, k <= 12, k == 1 || k == 7, k == 13, k <= 12, 1'b0});
    end
    set_cfg(32'd6, 32'd1, 32'd0, 32'd6, 2'd2);
    start_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start_i = 1'b0;
      check($sformatf("fullwin_k%0d", k), 32'(obs()), 32'(exp_q.pop_front()));
    end

    // Reset in the middle of an acquisition window.
    set_cfg(32'd10, 32'd3, 32'd2, 32'd5, 2'd0);
    start_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start_i = 1'b0;
    end
    check("pre_reset_acq", 32'(obs()), 32'(6'b010010));
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("midrun_reset_outputs", 32'(obs()), 32'(6'b0));
    check("midrun_reset_width", pulse_width_o, 32'd0);
    check("midrun_reset_idx", 32'(shot_idx_o), 32'd0);
    step();
    check("post_reset_idle", 32'(obs()), 32'(6'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/das_shot_scheduler.md
# das_shot_scheduler

Shot-timing controller for the DAS probe path. Generates the repetition-rate start strobes and latched pulse width that drive the optical pulse generator. Also produces the ADC acquisition window that frames each backscatter trace, for a programmed number of shots or continuously. Runs entirely in the ADC clock domain.

## Interface
- CNT_W, 32, width of period/width/delay/length counters and config inputs
- IDX_W, 16, width of shot count and shot index
- clk_adc_i  in  1  ADC sample clock; all logic on rising edge
- reset_i  in  1  synchronous reset, active-high
- start_i  in  1  launch a run; sampled only in IDLE
- stop_i  in  1  graceful stop request; run ends after the current shot completes
- period_i  in  CNT_W  shot repetition period, clock cycles
- pulse_width_i  in  CNT_W  probe pulse width forwarded to the pulse generator
- acq_delay_i  in  CNT_W  cycles from pulse start to first acquired sample
- acq_len_i  in  CNT_W  acquisition window length, cycles; 0 = no window
- shot_count_i  in  IDX_W  shots per run; 0 = continuous until stop
- pulse_start_o  out  1  one-cycle start strobe to the pulse generator
- pulse_width_o  out  CNT_W  width latched at run launch; held constant for the whole run
- acq_valid_o  out  1  high during the acquisition window
- frame_start_o  out  1  one-cycle strobe on the first cycle of acq_valid_o
- shot_idx_o  out  IDX_W  index of the current shot; 0 for the first shot
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle strobe when a run ends
- cfg_err_o  out  1  sticky; last start attempt was rejected

## Operation
- States: IDLE, RUN. Position counter pos (CNT_W) counts 0..period-1 within each shot.
- Reset: all outputs 0, state IDLE, pos 0, stop_pending 0.
- IDLE, start_i=1, stop_i=0: validate the inputs combinationally.
  - Reject if period_i < 2.
  - Reject if pulse_width_i == 0.
  - Reject if pulse_width_i >= period_i.
  - Reject if acq_delay_i + acq_len_i > period_i. Compute the sum in CNT_W+1 bits; no wrap.
  - Valid: latch all config, set cfg_err_o=0, and enter RUN with pos=0 and shot_idx_o=0.
  - Invalid: set cfg_err_o=1 and stay in IDLE.
- IDLE with start_i and stop_i both high: stop wins. Nothing starts and cfg_err_o is unchanged.
- RUN:
  - pulse_start_o = 1 exactly when pos==0.
  - acq_valid_o = 1 when acq_delay <= pos < acq_delay+acq_len. Registered output, aligned to pos.
  - frame_start_o = 1 when pos==acq_delay and acq_len != 0.
  - pos increments each cycle.
- End of shot (pos==period-1):
  - If stop_pending, or stop_i is high this cycle, or the finite count is reached (shot_idx==shot_count-1): go to IDLE and pulse done_o next cycle.
  - Otherwise: pos=0 and shot_idx_o+1. In continuous mode shot_idx_o wraps from 2^IDX_W-1 to 0.
- stop_i during RUN sets stop_pending. The current shot always completes, including its full acquisition window.
- start_i during RUN is ignored. Input config changes during RUN are ignored; latched values are used.
- busy_o = 1 in RUN.

## Timing
- start_i high at cycle T (valid config): at T+1, busy_o=1, pulse_start_o=1, shot_idx_o=0, pulse_width_o updated.
- Shot n's pulse_start_o occurs at T+1+n*period.
- acq_valid_o first rises at T+1+acq_delay. It spans acq_len cycles.
- Finite run: last shot ends at pos==period-1, cycle T+shot_count*period. At T+1+shot_count*period, done_o=1 and busy_o=0. start_i is accepted again in that same cycle.
- Rejected start at T: cfg_err_o=1 at T+1. No strobes are emitted.
- reset_i mid-run: all outputs 0 at the next edge. There is no partial done_o.
- Total latency from start to first pulse: 1 cycle.

## Test plan
- Finite run: period=10, width=3, delay=2, len=5, count=3, start at T.
  - pulse_start_o at T+1, T+11, T+21.
  - acq_valid_o during T+3..T+7 (and the matching windows in later shots).
  - frame_start_o at T+3, T+13, T+23.
  - done_o at T+31; busy_o falls at T+31.
- Config rejection:
  - period=8, delay=5, len=4 → cfg_err_o=1 at T+1; busy_o and pulse_start_o stay 0.
  - A following valid start clears cfg_err_o.
- Continuous mode with stop:
  - count=0, period=4. stop_i pulsed at pos==1 of shot 5.
  - Shot 5 completes; done_o is pulsed 3 cycles later; no shot 6 strobe.
- Boundary window:
  - delay=0, len=period=6 → acq_valid_o continuous across shots.
  - frame_start_o coincides with each pulse_start_o.
- Robustness:
  - start and stop together in IDLE → no run.
  - Change period_i mid-run → spacing unchanged.
  - reset_i mid-acquisition → all outputs 0 at the next edge.
  - IDX_W=2, continuous run → shot_idx_o wraps 3→0.
